// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: sync, draw enable and pixel coordinates from pixelclock.
// Optional `VGA_FRAME_COUNT_EN adds an 8-bit frame_count output that steps with each frame_start.
module vga_sync_gen #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int CNT_W    = 10
) (
    input  logic             pixelclock,
    input  logic             reset,
    input  logic             enable,
    output logic             hsinc,
    output logic             vsinc,
    output logic             draw,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             frame_start,
    output logic             line_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0]       frame_count
`endif
);

    localparam int H_TOTAL       = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL       = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START  = H_VIS + H_FP;
    localparam int H_BACK_START  = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START  = V_VIS + V_FP;
    localparam int V_BACK_START  = V_SYNC_START + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    localparam logic SYNC_ON  = (SYNC_POL != 0);
    localparam logic SYNC_OFF = (SYNC_POL == 0);

    localparam logic [1:0] HS_VISIBLE = 2'd0;
    localparam logic [1:0] HS_FRONT   = 2'd1;
    localparam logic [1:0] HS_SYNC    = 2'd2;
    localparam logic [1:0] HS_BACK    = 2'd3;

    localparam logic [1:0] VS_VISIBLE = 2'd0;
    localparam logic [1:0] VS_FRONT   = 2'd1;
    localparam logic [1:0] VS_SYNC    = 2'd2;
    localparam logic [1:0] VS_BACK    = 2'd3;

    // The counters must be able to hold H_TOTAL-1 / V_TOTAL-1.
    if (H_TOTAL > (1 << CNT_W)) begin : g_h_width_chk
        $error("vga_sync_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (V_TOTAL > (1 << CNT_W)) begin : g_v_width_chk
        $error("vga_sync_gen: V_TOTAL does not fit in CNT_W bits");
    end

    logic [1:0]       h_state;
    logic [1:0]       v_state;
    logic [1:0]       h_state_nxt;
    logic [1:0]       v_state_nxt;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             h_wrap;
    logic             v_wrap;

    // Next raster position and FSM states; outputs are registered from these
    // so sync/draw line up with the coordinates presented in the same cycle.
    always_comb begin
        h_wrap = (h_count == H_LAST);
        v_wrap = (v_count == V_LAST);

        h_nxt = h_wrap ? '0 : h_count + CNT_W'(1);
        v_nxt = v_count;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : v_count + CNT_W'(1);
        end

        // Later boundaries are tested first so a zero-length region is skipped.
        h_state_nxt = h_state;
        if (32'(h_nxt) == H_BACK_START) begin
            h_state_nxt = HS_BACK;
        end else if (32'(h_nxt) == H_SYNC_START) begin
            h_state_nxt = HS_SYNC;
        end else if (32'(h_nxt) == H_VIS) begin
            h_state_nxt = HS_FRONT;
        end else if (h_nxt == '0) begin
            h_state_nxt = HS_VISIBLE;
        end

        v_state_nxt = v_state;
        if (h_wrap) begin
            if (32'(v_nxt) == V_BACK_START) begin
                v_state_nxt = VS_BACK;
            end else if (32'(v_nxt) == V_SYNC_START) begin
                v_state_nxt = VS_SYNC;
            end else if (32'(v_nxt) == V_VIS) begin
                v_state_nxt = VS_FRONT;
            end else if (v_nxt == '0) begin
                v_state_nxt = VS_VISIBLE;
            end
        end
    end

    // Reset parks the raster on its last pixel so the first enabled edge lands on (0,0).
    always_ff @(posedge pixelclock) begin
        if (reset) begin
            h_count     <= H_LAST;
            v_count     <= V_LAST;
            h_state     <= HS_BACK;
            v_state     <= VS_BACK;
            hsinc       <= SYNC_OFF;
            vsinc       <= SYNC_OFF;
            draw        <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else if (enable) begin
            h_count     <= h_nxt;
            v_count     <= v_nxt;
            h_state     <= h_state_nxt;
            v_state     <= v_state_nxt;
            hsinc       <= (h_state_nxt == HS_SYNC) ? SYNC_ON : SYNC_OFF;
            vsinc       <= (v_state_nxt == VS_SYNC) ? SYNC_ON : SYNC_OFF;
            draw        <= (h_state_nxt == HS_VISIBLE) && (v_state_nxt == VS_VISIBLE);
            frame_start <= h_wrap && v_wrap;
            line_start  <= h_wrap;
        end else begin
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge pixelclock) begin
        if (reset) begin
            frame_count <= 8'd0;
        end else if (enable && h_wrap && v_wrap) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: directed vector table on a default 640x480 instance, plus
// whole-frame scans on a small active-high instance (frame_count when VGA_FRAME_COUNT_EN).
module tb_vga_sync_gen;

    logic pixelclock = 1'b0;
    always #5 pixelclock = ~pixelclock;

    int n_vec  = 0;
    int n_fail = 0;

    // Default-timing instance.
    logic       a_reset, a_enable;
    logic       a_hs, a_vs, a_draw, a_fs, a_ls;
    logic [9:0] a_h, a_v;

    // Small instance: 16x12 raster, active-high sync, CNT_W exactly fits H_TOTAL.
    logic       b_reset, b_enable;
    logic       b_hs, b_vs, b_draw, b_fs, b_ls;
    logic [3:0] b_h, b_v;

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] a_fc, b_fc;
    localparam int FRAMES = 256;
`else
    localparam int FRAMES = 2;
`endif
    localparam int B_FRAME = 16 * 12;

    vga_sync_gen dut_a (
        .pixelclock (pixelclock),
        .reset      (a_reset),
        .enable     (a_enable),
        .hsinc      (a_hs),
        .vsinc      (a_vs),
        .draw       (a_draw),
        .h_count    (a_h),
        .v_count    (a_v),
        .frame_start(a_fs),
        .line_start (a_ls)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_count(a_fc)
`endif
    );

    vga_sync_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1), .CNT_W(4)
    ) dut_b (
        .pixelclock (pixelclock),
        .reset      (b_reset),
        .enable     (b_enable),
        .hsinc      (b_hs),
        .vsinc      (b_vs),
        .draw       (b_draw),
        .h_count    (b_h),
        .v_count    (b_v),
        .frame_start(b_fs),
        .line_start (b_ls)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_count(b_fc)
`endif
    );

    typedef struct {
        logic       rst;
        logic       en;
        int         cycles;
        logic [9:0] h;
        logic [9:0] v;
        logic       d;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       ls;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl[NV];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixelclock);
        #1;
    endtask

    initial begin
        int ref_h, ref_v, adv, cyc, last_fs_adv;
        int hs_pulses, vs_pulses, fs_pulses;
        logic en, prev_hs, prev_vs;
        logic e_hs, e_vs, e_d, e_fs, e_ls;
        logic [7:0] exp_fc;

        // Fields: rst, en, cycles, h, v, draw, hsinc, vsinc, frame_start, line_start
        tbl[0]  = '{1'b1, 1'b1, 1,   10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1,   10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 639, 10'd639, 10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1,   10'd640, 10'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 15,  10'd655, 10'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1,   10'd656, 10'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 95,  10'd751, 10'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1,   10'd752, 10'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 47,  10'd799, 10'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1,   10'd0,   10'd1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1,   10'd0,   10'd1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 655, 10'd655, 10'd1,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 10,  10'd655, 10'd1,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1,   10'd656, 10'd1,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 444, 10'd300, 10'd2,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 1,   10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 1,   10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 1'b1, 800, 10'd0,   10'd1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 1'b1, 5,   10'd5,   10'd1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 1,   10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 3,   10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 1'b1, 1,   10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        a_reset  = 1'b1;
        a_enable = 1'b1;
        b_reset  = 1'b1;
        b_enable = 1'b1;

        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < tbl[i].cycles; k++) begin
                a_reset  = tbl[i].rst;
                a_enable = tbl[i].en;
                tick();
            end
            check($sformatf("vec%0d", i),
                  {a_h, a_v, a_draw, a_hs, a_vs, a_fs, a_ls},
                  {tbl[i].h, tbl[i].v, tbl[i].d, tbl[i].hs, tbl[i].vs, tbl[i].fs, tbl[i].ls});
        end

        // Small instance: reset state (sync inactive = 0 with active-high polarity).
        b_reset  = 1'b1;
        b_enable = 1'b1;
        tick();
        check("b_reset", {b_h, b_v, b_draw, b_hs, b_vs, b_fs, b_ls}, {4'd15, 4'd11, 5'b00000});
`ifdef VGA_FRAME_COUNT_EN
        check("b_fc_reset", b_fc, 8'd0);
`endif

        // Whole frames with a periodic enable gap, against a coordinate model.
        b_reset     = 1'b0;
        ref_h       = 15;
        ref_v       = 11;
        adv         = 0;
        cyc         = 0;
        last_fs_adv = 0;
        hs_pulses   = 0;
        vs_pulses   = 0;
        fs_pulses   = 0;
        prev_hs     = 1'b0;
        prev_vs     = 1'b0;
        exp_fc      = 8'd0;
        while (adv < FRAMES * B_FRAME) begin
            en       = ((cyc % 7) != 3);
            b_enable = en;
            tick();
            cyc++;
            if (en) begin
                adv++;
                if (ref_h == 15) begin
                    ref_h = 0;
                    ref_v = (ref_v == 11) ? 0 : ref_v + 1;
                end else begin
                    ref_h++;
                end
            end
            e_hs = (ref_h >= 10) && (ref_h <= 12);
            e_vs = (ref_v >= 8) && (ref_v <= 9);
            e_d  = (ref_h < 8) && (ref_v < 6);
            e_ls = en && (ref_h == 0);
            e_fs = e_ls && (ref_v == 0);
            check($sformatf("b_scan c%0d", cyc),
                  {b_h, b_v, b_draw, b_hs, b_vs, b_fs, b_ls},
                  {ref_h[3:0], ref_v[3:0], e_d, e_hs, e_vs, e_fs, e_ls});
            if (b_hs && !prev_hs) hs_pulses++;
            if (b_vs && !prev_vs) vs_pulses++;
            prev_hs = b_hs;
            prev_vs = b_vs;
            if (b_fs) begin
                fs_pulses++;
                if (fs_pulses > 1) check("b_frame_len", adv - last_fs_adv, B_FRAME);
                last_fs_adv = adv;
`ifdef VGA_FRAME_COUNT_EN
                exp_fc = exp_fc + 8'd1;
                check($sformatf("b_frame_count f%0d", fs_pulses), b_fc, exp_fc);
`endif
            end
        end
        check("b_hs_pulses", hs_pulses, FRAMES * 12);
        check("b_vs_pulses", vs_pulses, FRAMES);
        check("b_fs_pulses", fs_pulses, FRAMES);
`ifdef VGA_FRAME_COUNT_EN
        check("b_fc_wrapped", b_fc, 8'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
